pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline stage register with valid/ready handshake, a two-entry skid buffer, synchronous flush and a bubble counter. Sits between any two pipeline stages (ID/EXE first, then EXE/MEM and MEM/WB). It carries PC, instruction, packed control, packed operand data and destination register. It replaces the free-running per-field stage registers so that stalls and flushes are handled inside the stage instead of by the hazard unit gating clocks.

## Interface
- LEN, 32, PC and instruction width
- CTRL_W, 9, packed control width: wb_en[0], mem_read[1], mem_write[2], branch_type[4:3], exe_cmd[8:5]
- DATA_W, 96, packed operand width: {alu_inp2, alu_inp1, reg2}
- DEST_W, 5, destination register index width
- CNT_W, 16, bubble counter width

- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserted (0) forces reset state immediately
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept this cycle
- in_pc / in_inst  in  LEN  upstream PC / instruction
- in_ctrl  in  CTRL_W  upstream control
- in_data  in  DATA_W  upstream operands
- in_dest  in  DEST_W  upstream destination
- out_valid  out  1  output entry present
- out_ready  in  1  downstream consumes this cycle
- out_pc / out_inst  out  LEN  held PC / instruction
- out_ctrl  out  CTRL_W  control; forced 0 when out_valid=0
- out_data  out  DATA_W  held operands
- out_dest  out  DEST_W  destination; forced 0 when out_valid=0
- bubble_cnt  out  CNT_W  saturating count of cycles with out_valid=0

## Operation
- Two entries: M (drives outputs) and S (skid). State: EMPTY (M invalid), ONE (M valid, S invalid), FULL (both valid).
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- in_ready is a register: 1 in EMPTY/ONE, 0 in FULL. It is never combinationally dependent on out_ready.
- EMPTY: accept → M←in, ONE; else stay.
- ONE: accept & drain → M←in, stay ONE. Accept & !drain → S←in, FULL. !accept & drain → EMPTY. Otherwise hold.
- FULL: drain → M←S, ONE; else hold. No accept is possible.
- flush=1 has highest priority: next state EMPTY and in_ready←1. Any same-cycle accept is dropped and drain is ignored. Data fields of M/S are left unchanged (don't care).
- Bubble outputs: out_ctrl and out_dest read 0 whenever out_valid=0, so wb_en/mem_write are never active on a bubble. out_pc/out_inst/out_data hold their last loaded values.
- bubble_cnt increments by 1 on each clock edge where out_valid=0 was sampled. It saturates at 2^CNT_W−1 and is cleared only by reset.
- Entry order is strictly FIFO. No entry is duplicated or lost except by flush.

## Timing
- Reset (reset=0): state EMPTY, out_valid=0, in_ready=1, all M/S fields 0, out_ctrl=0, out_dest=0, bubble_cnt=0. The reset is asynchronous and outputs change without a clock.
- Latency: an entry accepted at edge n is on the outputs with out_valid=1 after edge n (visible in cycle n+1).
- Throughput: 1 entry/cycle while out_ready=1 continuously.
- Backpressure: in_ready falls one cycle after the first cycle with out_ready=0 and a held entry. The skid entry absorbs the in-flight accept.
- Release: in FULL with out_ready=1, in_ready rises after that edge. The next accept is possible in the following cycle.
- Simultaneous flush & reset deassert: reset wins until released. The first edge after release applies flush normally.
- Reset asserted mid-operation discards M and S.

## Structure
- Package pipe_pkg holds:
  - the state enum (EMPTY, ONE, FULL);
  - the CTRL field offset/width constants (WB_EN_BIT, MEM_READ_BIT, MEM_WRITE_BIT, BR_TYPE_LSB/W, EXE_CMD_LSB/W);
  - the default widths.
- One sub-module, pipe_entry_reg: WIDTH-parameter register with async active-low reset and load enable. It is instantiated for M and for S over the concatenated {pc, inst, ctrl, data, dest} bus.
- The FSM, in_ready register and bubble counter live in the top module.

## Test plan
- Reset: hold reset=0 with random inputs → out_valid=0, in_ready=1, out_ctrl=0, bubble_cnt=0. After release with no input for 5 cycles → bubble_cnt=5.
- Streaming: in_valid=1 and out_ready=1 for 8 cycles with pc=0x00,0x04,…,0x1C → out_pc follows one cycle later in order, no gaps, bubble_cnt unchanged during streaming.
- Backpressure: stream pc=0x100,0x104,0x108 and drop out_ready for 3 cycles starting when 0x100 is on the outputs → in_ready=0 after one cycle, S holds 0x104. On release the outputs are 0x100, 0x104, 0x108 in order, each exactly once.
- Flush in FULL: fill M=0x200, S=0x204, pulse flush with in_valid=1 (pc=0x208) → next cycle out_valid=0, out_ctrl=0, in_ready=1, and 0x208 never appears.
- Bubble control masking: accept ctrl=9'h1FF, dest=5'd31, then idle → after the drain cycle out_ctrl=0 and out_dest=0 while out_pc still reads the drained PC.
- Saturation: CNT_W=4 with idle for 20 cycles → bubble_cnt stops at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline stage: occupancy states,
// packed control field layout and default field widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    // Bit positions inside the packed control word
    localparam int WB_EN_BIT     = 0;
    localparam int MEM_READ_BIT  = 1;
    localparam int MEM_WRITE_BIT = 2;
    localparam int BR_TYPE_LSB   = 3;
    localparam int BR_TYPE_W     = 2;
    localparam int EXE_CMD_LSB   = 5;
    localparam int EXE_CMD_W     = 4;

    localparam int DEF_LEN    = 32;
    localparam int DEF_CTRL_W = 9;
    localparam int DEF_DATA_W = 96;
    localparam int DEF_DEST_W = 5;
    localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/pipe_entry_reg.sv
// Loadable storage for one pipeline entry, cleared by the asynchronous
// active-low reset.
module pipe_entry_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, a main entry (M) that
// drives the outputs, a skid entry (S) that absorbs the in-flight accept,
// synchronous flush and a saturating bubble counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int LEN    = DEF_LEN,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEST_W = DEF_DEST_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LEN-1:0]    in_pc,
    input  logic [LEN-1:0]    in_inst,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LEN-1:0]    out_pc,
    output logic [LEN-1:0]    out_inst,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [DEST_W-1:0] out_dest,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int ENTRY_W = 2 * LEN + CTRL_W + DATA_W + DEST_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    pipe_state_e        state;
    pipe_state_e        state_next;
    logic               accept;
    logic               drain;
    logic               load_m;
    logic               load_s;
    logic               m_from_s;
    logic [ENTRY_W-1:0] in_entry;
    logic [ENTRY_W-1:0] m_d;
    logic [ENTRY_W-1:0] m_entry;
    logic [ENTRY_W-1:0] s_entry;
    logic [CTRL_W-1:0]  m_ctrl;
    logic [DEST_W-1:0]  m_dest;

    assign in_entry  = {in_pc, in_inst, in_ctrl, in_data, in_dest};
    assign accept    = in_valid & in_ready;
    assign out_valid = (state != EMPTY);
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_next = state;
        load_m     = 1'b0;
        load_s     = 1'b0;
        m_from_s   = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        load_m     = 1'b1;
                        state_next = ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        load_m = 1'b1;
                    end else if (accept) begin
                        load_s     = 1'b1;
                        state_next = FULL;
                    end else if (drain) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        load_m     = 1'b1;
                        m_from_s   = 1'b1;
                        state_next = ONE;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    assign m_d = m_from_s ? s_entry : in_entry;

    // in_ready is registered from the next state so it never depends on out_ready
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_next;
            in_ready <= (state_next != FULL);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bubble_cnt <= '0;
        end else if (!out_valid && (bubble_cnt != CNT_MAX)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

    pipe_entry_reg #(.WIDTH(ENTRY_W)) u_m_reg (
        .clock (clock),
        .reset (reset),
        .load  (load_m),
        .d     (m_d),
        .q     (m_entry)
    );

    pipe_entry_reg #(.WIDTH(ENTRY_W)) u_s_reg (
        .clock (clock),
        .reset (reset),
        .load  (load_s),
        .d     (in_entry),
        .q     (s_entry)
    );

    // Control and destination are masked on bubbles so no write can fire
    assign {out_pc, out_inst, m_ctrl, out_data, m_dest} = m_entry;
    assign out_ctrl = out_valid ? m_ctrl : '0;
    assign out_dest = out_valid ? m_dest : '0;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed handshake scenarios plus
// randomized traffic compared against a queue-based reference model.
module tb_pipe_stage_skid;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [8:0]  ctrl;
        logic [95:0] data;
        logic [4:0]  dest;
    } entry_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    logic [8:0]  in_ctrl = '0;
    logic [95:0] in_data = '0;
    logic [4:0]  in_dest = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [8:0]  out_ctrl;
    logic [95:0] out_data;
    logic [4:0]  out_dest;
    logic [15:0] bubble_cnt;

    logic        sat_in_valid = 1'b0;
    logic        sat_in_ready;
    logic        sat_out_valid;
    logic [31:0] sat_out_pc;
    logic [31:0] sat_out_inst;
    logic [8:0]  sat_out_ctrl;
    logic [95:0] sat_out_data;
    logic [4:0]  sat_out_dest;
    logic [3:0]  sat_bubble_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    entry_t mq[$];
    entry_t m_last;
    bit     m_ready;
    int     m_cnt;

    always #5 clock = ~clock;

    pipe_stage_skid dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_ctrl(in_ctrl),
        .in_data(in_data), .in_dest(in_dest),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_ctrl(out_ctrl),
        .out_data(out_data), .out_dest(out_dest),
        .bubble_cnt(bubble_cnt)
    );

    pipe_stage_skid #(.CNT_W(4)) dut_sat (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(sat_in_valid), .in_ready(sat_in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_ctrl(in_ctrl),
        .in_data(in_data), .in_dest(in_dest),
        .out_valid(sat_out_valid), .out_ready(out_ready),
        .out_pc(sat_out_pc), .out_inst(sat_out_inst), .out_ctrl(sat_out_ctrl),
        .out_data(sat_out_data), .out_dest(sat_out_dest),
        .bubble_cnt(sat_bubble_cnt)
    );

    task automatic model_reset();
        mq.delete();
        m_last  = '0;
        m_ready = 1'b1;
        m_cnt   = 0;
    endtask

    // The stage behaves as a FIFO of depth two whose ready flag lags by one edge
    task automatic model_edge();
        entry_t e;
        bit acc;
        bit drn;
        e.pc   = in_pc;
        e.inst = in_inst;
        e.ctrl = in_ctrl;
        e.data = in_data;
        e.dest = in_dest;
        acc = in_valid && m_ready;
        drn = (mq.size() > 0) && out_ready;
        if (mq.size() == 0 && m_cnt < 65535) m_cnt++;
        if (flush) begin
            mq.delete();
        end else begin
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back(e);
        end
        if (mq.size() > 0) m_last = mq[0];
        m_ready = (mq.size() < 2);
    endtask

    task automatic tick();
        if (reset) model_edge();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input logic [8:0] ctrl,
                         input logic [4:0] dest, input bit rdy, input bit fl);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = $urandom;
        in_ctrl   = ctrl;
        in_data   = {$urandom, $urandom, $urandom};
        in_dest   = dest;
        out_ready = rdy;
        flush     = fl;
    endtask

    task automatic test_reset();
        model_reset();
        @(negedge clock);
        repeat (3) begin
            drive($urandom_range(1), $urandom, 9'($urandom), 5'($urandom), $urandom_range(1), 1'b0);
            @(negedge clock);
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_ctrl !== 9'h0) begin n_fail++; $display("[TB] FAIL reset out_ctrl: got %h want 0", out_ctrl); end
        n_checks++; if (bubble_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL reset bubble_cnt: got %0d want 0", bubble_cnt); end
        reset = 1'b1;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        repeat (5) tick();
        n_checks++; if (bubble_cnt !== 16'd5) begin n_fail++; $display("[TB] FAIL idle bubble_cnt: got %0d want 5", bubble_cnt); end
    endtask

    task automatic test_streaming();
        int cnt_stream;
        cnt_stream = m_cnt + 1;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) begin
                n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stream out_valid step %0d: got %b want 1", k, out_valid); end
                n_checks++; if (out_pc !== 32'((k - 1) * 4)) begin n_fail++; $display("[TB] FAIL stream out_pc step %0d: got %h want %h", k, out_pc, (k - 1) * 4); end
                n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL stream in_ready step %0d: got %b want 1", k, in_ready); end
                n_checks++; if (bubble_cnt !== 16'(cnt_stream)) begin n_fail++; $display("[TB] FAIL stream bubble_cnt step %0d: got %0d want %0d", k, bubble_cnt, cnt_stream); end
            end
            if (k < 8) drive(1'b1, 32'(k * 4), 9'($urandom), 5'($urandom), 1'b1, 1'b0);
            else       drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
            tick();
        end
    endtask

    task automatic test_backpressure();
        bit          tv[8] = '{1, 1, 1, 1, 1, 1, 0, 0};
        bit          tr[8] = '{1, 0, 0, 0, 1, 1, 1, 1};
        bit          er[8] = '{1, 1, 0, 0, 0, 1, 1, 1};
        logic [31:0] tp[8] = '{32'h100, 32'h104, 32'h108, 32'h108, 32'h108, 32'h108, 32'h0, 32'h0};
        logic [31:0] want[3] = '{32'h100, 32'h104, 32'h108};
        logic [31:0] drained[$];
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (in_ready !== er[k]) begin n_fail++; $display("[TB] FAIL bp in_ready step %0d: got %b want %b", k, in_ready, er[k]); end
            if (out_valid && tr[k]) drained.push_back(out_pc);
            drive(tv[k], tp[k], 9'($urandom), 5'($urandom), tr[k], 1'b0);
            tick();
        end
        n_checks++; if (drained.size() != 3) begin n_fail++; $display("[TB] FAIL bp drain count: got %0d want 3", drained.size()); end
        for (int k = 0; k < 3; k++) begin
            if (k < drained.size()) begin
                n_checks++; if (drained[k] !== want[k]) begin n_fail++; $display("[TB] FAIL bp drain order %0d: got %h want %h", k, drained[k], want[k]); end
            end
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h200, 9'h1FF, 5'd7, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h204, 9'h1FF, 5'd8, 1'b0, 1'b0); tick();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL flush pre in_ready: got %b want 0", in_ready); end
        drive(1'b1, 32'h208, 9'h1FF, 5'd9, 1'b0, 1'b1); tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_ctrl !== 9'h0) begin n_fail++; $display("[TB] FAIL flush out_ctrl: got %h want 0", out_ctrl); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL flush in_ready: got %b want 1", in_ready); end
        repeat (3) begin
            drive(1'b0, '0, '0, '0, 1'b1, 1'b0); tick();
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush ghost entry: got valid %b pc %h want 0", out_valid, out_pc); end
        end
        drive(1'b1, 32'h210, 9'h0AA, 5'd3, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h214, 9'h0AA, 5'd4, 1'b1, 1'b1); tick();
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0); tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush dropped accept: got valid %b pc %h want 0", out_valid, out_pc); end
        n_checks++; if (bubble_cnt !== 16'(m_cnt)) begin n_fail++; $display("[TB] FAIL flush bubble_cnt: got %0d want %0d", bubble_cnt, m_cnt); end
    endtask

    task automatic test_bubble_mask();
        drive(1'b1, 32'h300, 9'h1FF, 5'd31, 1'b0, 1'b0); tick();
        n_checks++; if (out_ctrl !== 9'h1FF) begin n_fail++; $display("[TB] FAIL mask live ctrl: got %h want 1ff", out_ctrl); end
        n_checks++; if (out_dest !== 5'd31) begin n_fail++; $display("[TB] FAIL mask live dest: got %0d want 31", out_dest); end
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0); tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mask out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_ctrl !== 9'h0) begin n_fail++; $display("[TB] FAIL mask bubble ctrl: got %h want 0", out_ctrl); end
        n_checks++; if (out_dest !== 5'd0) begin n_fail++; $display("[TB] FAIL mask bubble dest: got %0d want 0", out_dest); end
        n_checks++; if (out_pc !== 32'h300) begin n_fail++; $display("[TB] FAIL mask held pc: got %h want 300", out_pc); end
    endtask

    task automatic test_random();
        bit     exp_valid;
        entry_t f;
        for (int i = 0; i < 400; i++) begin
            exp_valid = (mq.size() > 0);
            f = m_last;
            n_checks++; if (out_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL rand out_valid cycle %0d: got %b want %b", i, out_valid, exp_valid); end
            n_checks++; if (in_ready !== m_ready) begin n_fail++; $display("[TB] FAIL rand in_ready cycle %0d: got %b want %b", i, in_ready, m_ready); end
            n_checks++; if (out_pc !== f.pc) begin n_fail++; $display("[TB] FAIL rand out_pc cycle %0d: got %h want %h", i, out_pc, f.pc); end
            n_checks++; if (out_inst !== f.inst) begin n_fail++; $display("[TB] FAIL rand out_inst cycle %0d: got %h want %h", i, out_inst, f.inst); end
            n_checks++; if (out_data !== f.data) begin n_fail++; $display("[TB] FAIL rand out_data cycle %0d: got %h want %h", i, out_data, f.data); end
            n_checks++; if (out_ctrl !== (exp_valid ? f.ctrl : 9'h0)) begin n_fail++; $display("[TB] FAIL rand out_ctrl cycle %0d: got %h want %h", i, out_ctrl, exp_valid ? f.ctrl : 9'h0); end
            n_checks++; if (out_dest !== (exp_valid ? f.dest : 5'h0)) begin n_fail++; $display("[TB] FAIL rand out_dest cycle %0d: got %h want %h", i, out_dest, exp_valid ? f.dest : 5'h0); end
            n_checks++; if (bubble_cnt !== 16'(m_cnt)) begin n_fail++; $display("[TB] FAIL rand bubble_cnt cycle %0d: got %0d want %0d", i, bubble_cnt, m_cnt); end
            drive($urandom_range(3) != 0, $urandom, 9'($urandom), 5'($urandom),
                  $urandom_range(3) != 0, $urandom_range(15) == 0);
            tick();
        end
    endtask

    task automatic test_async_reset();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1); tick();
        drive(1'b1, 32'h400, 9'h1FF, 5'd1, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h404, 9'h1FF, 5'd2, 1'b0, 1'b0); tick();
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        #3 reset = 1'b0;
        model_reset();
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL async out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL async in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL async out_pc: got %h want 0", out_pc); end
        n_checks++; if (bubble_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL async bubble_cnt: got %0d want 0", bubble_cnt); end
        @(negedge clock);
        reset = 1'b1;
        repeat (2) tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL async discard: got valid %b pc %h want 0", out_valid, out_pc); end
    endtask

    task automatic test_saturation();
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        reset = 1'b0;
        model_reset();
        #2 reset = 1'b1;
        repeat (10) tick();
        n_checks++; if (sat_bubble_cnt !== 4'd10) begin n_fail++; $display("[TB] FAIL sat count 10: got %0d want 10", sat_bubble_cnt); end
        repeat (10) tick();
        n_checks++; if (sat_bubble_cnt !== 4'd15) begin n_fail++; $display("[TB] FAIL sat count 15: got %0d want 15", sat_bubble_cnt); end
        n_checks++; if (sat_in_ready !== 1'b1 || sat_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL sat idle handshake: got ready %b valid %b want 1 0", sat_in_ready, sat_out_valid); end
        n_checks++; if (bubble_cnt !== 16'd20) begin n_fail++; $display("[TB] FAIL wide count 20: got %0d want 20", bubble_cnt); end
    endtask

    initial begin
        $display("[TB] pipe_stage_skid bench start");
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_bubble_mask();
        test_random();
        test_async_reset();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
